// File: rtl/bts_mem_traffic_gen.sv
// PRBS31 memory traffic generator/checker: a write pass of PRBS bursts, then a read-back
// pass compared beat by beat. Define BTS_TGEN_LOOP_EN to allow back-to-back passes via loop.
module bts_mem_traffic_gen #(
   parameter int unsigned DATA_WIDTH      = 160,
   parameter int unsigned BE_WIDTH        = 20,
   parameter int unsigned ADDR_WIDTH      = 23,
   parameter int unsigned SIZE_WIDTH      = 3,
   parameter int unsigned BURST_LEN       = 4,
   parameter int unsigned NUM_BURSTS      = 1024,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter logic [31:0] SEED            = 32'h1234_5678
) (
   input  logic                  local_clk,
   input  logic                  local_reset,
   input  logic                  start,
   input  logic                  inject_err,
   input  logic                  loop,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic                  local_init_done,
   input  logic                  local_ready,
   output logic [ADDR_WIDTH-1:0] local_addr,
   output logic [SIZE_WIDTH-1:0] local_size,
   output logic [BE_WIDTH-1:0]   local_be,
   output logic                  local_burst_begin,
   output logic                  local_write_req,
   output logic [DATA_WIDTH-1:0] local_wdata,
   output logic                  local_read_req,
   input  logic [DATA_WIDTH-1:0] local_rdata,
   input  logic                  local_rdata_valid,
   output logic                  busy,
   output logic                  test_complete,
   output logic [BE_WIDTH-1:0]   err_lanes,
   output logic [31:0]           err_count,
   output logic [ADDR_WIDTH-1:0] first_err_addr,
   output logic [15:0]           pass_count
);

   localparam int unsigned NUM_SLICES  = DATA_WIDTH / 32;
   localparam int unsigned TOTAL_BEATS = NUM_BURSTS * BURST_LEN;
   localparam int unsigned BEAT_CW     = $clog2(TOTAL_BEATS + 1);
   localparam int unsigned REQ_CW      = $clog2(NUM_BURSTS + 1);
   localparam int unsigned OUT_CW      = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [ADDR_WIDTH-1:0] BURST_STEP    = ADDR_WIDTH'(BURST_LEN);
   localparam logic [SIZE_WIDTH-1:0] SIZE_VAL      = SIZE_WIDTH'(BURST_LEN);
   localparam logic [SIZE_WIDTH-1:0] LAST_IN_BURST = SIZE_WIDTH'(BURST_LEN - 1);
   localparam logic [BEAT_CW-1:0]    LAST_BEAT     = BEAT_CW'(TOTAL_BEATS - 1);
   localparam logic [REQ_CW-1:0]     LAST_REQ      = REQ_CW'(NUM_BURSTS - 1);
   localparam logic [OUT_CW-1:0]     MAX_OUT       = OUT_CW'(MAX_OUTSTANDING);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_INIT,
      ST_WRITE,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t state, state_next;

   logic [31:0]           wr_lfsr;
   logic [31:0]           chk_lfsr;
   logic [31:0]           pass_seed;
   logic [BEAT_CW-1:0]    wr_cnt;
   logic [SIZE_WIDTH-1:0] wr_beat;
   logic [REQ_CW-1:0]     rd_cnt;
   logic [SIZE_WIDTH-1:0] ret_beat;
   logic [OUT_CW-1:0]     outstanding, out_next;
   logic [ADDR_WIDTH-1:0] chk_addr;
   logic                  inj_pending;
   logic                  err_seen;

   logic                  start_acc;
   logic                  wr_acc, wr_last, wr_load, enter_write;
   logic                  rd_acc, rd_ret, ret_last, rreq_next;
   logic                  loop_again;
   logic [BE_WIDTH-1:0]   lane_err;

`ifdef BTS_TGEN_LOOP_EN
   assign loop_again = loop;
`else
   assign loop_again = loop & 1'b0;
`endif

   function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
      return {s[30:0], s[30] ^ s[27]};
   endfunction

   function automatic logic [DATA_WIDTH-1:0] pattern(input logic [31:0] s);
      logic [DATA_WIDTH-1:0] d;
      logic [31:0]           r;
      d = '0;
      r = s;
      for (int unsigned i = 0; i < NUM_SLICES; i++) begin
         d[i*32 +: 32] = r;
         r = {r[30:0], r[31]};
      end
      return d;
   endfunction

   function automatic logic [BE_WIDTH-1:0] lane_diff(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
      logic [BE_WIDTH-1:0] m;
      m = '0;
      for (int unsigned j = 0; j < BE_WIDTH; j++) m[j] = |(a[j*8 +: 8] ^ b[j*8 +: 8]);
      return m;
   endfunction

   assign wr_acc      = (state == ST_WRITE) && local_write_req && local_ready;
   assign wr_last     = wr_acc && (wr_cnt == LAST_BEAT);
   assign rd_acc      = (state == ST_READ) && local_read_req && local_ready;
   assign rd_ret      = ((state == ST_READ) || (state == ST_DRAIN)) && local_rdata_valid;
   assign ret_last    = rd_ret && (ret_beat == LAST_IN_BURST);
   assign enter_write = (state_next == ST_WRITE) && (state != ST_WRITE);
   assign wr_load     = enter_write || (wr_acc && !wr_last);
   assign lane_err    = lane_diff(local_rdata, pattern(chk_lfsr));
   assign out_next    = outstanding + OUT_CW'(rd_acc) - OUT_CW'(ret_last);
   assign rreq_next   = (state_next == ST_READ) && (out_next < MAX_OUT);

   always_ff @(posedge local_clk) begin
      if (local_reset) state <= ST_IDLE;
      else             state <= state_next;
   end

   always_comb begin
      state_next = state;
      start_acc  = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_next = ST_WAIT_INIT;
               start_acc  = 1'b1;
            end
         end
         ST_WAIT_INIT: if (local_init_done) state_next = ST_WRITE;
         ST_WRITE:     if (wr_last) state_next = ST_READ;
         ST_READ:      if (rd_acc && (rd_cnt == LAST_REQ)) state_next = ST_DRAIN;
         ST_DRAIN:     if (outstanding == '0) state_next = loop_again ? ST_WRITE : ST_DONE;
         default:      state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge local_clk) begin
      if (local_reset) begin
         local_addr        <= '0;
         local_size        <= SIZE_VAL;
         local_be          <= '1;
         local_burst_begin <= 1'b0;
         local_write_req   <= 1'b0;
         local_wdata       <= '0;
         local_read_req    <= 1'b0;
         busy              <= 1'b0;
         test_complete     <= 1'b0;
         err_lanes         <= '0;
         err_count         <= '0;
         first_err_addr    <= '0;
         pass_count        <= '0;
         wr_lfsr           <= SEED;
         chk_lfsr          <= SEED;
         pass_seed         <= SEED;
         wr_cnt            <= '0;
         wr_beat           <= '0;
         rd_cnt            <= '0;
         ret_beat          <= '0;
         outstanding       <= '0;
         chk_addr          <= '0;
         inj_pending       <= 1'b0;
         err_seen          <= 1'b0;
      end else begin
         local_size    <= SIZE_VAL;
         local_be      <= '1;
         outstanding   <= out_next;
         busy          <= (state_next != ST_IDLE) && (state_next != ST_DONE);
         test_complete <= (state_next == ST_DONE);

         if (start_acc) begin
            err_lanes      <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            pass_count     <= '0;
            err_seen       <= 1'b0;
            wr_lfsr        <= SEED;
            chk_lfsr       <= SEED;
            ret_beat       <= '0;
         end

         if (wr_load)         inj_pending <= 1'b0;
         else if (inject_err) inj_pending <= 1'b1;

         // Next beat is loaded only on acceptance so wdata holds while stalled.
         if (wr_load) begin
            local_wdata <= pattern(wr_lfsr) ^ DATA_WIDTH'(inj_pending | inject_err);
            wr_lfsr     <= lfsr_adv(wr_lfsr);
         end

         if (enter_write) begin
            local_write_req   <= 1'b1;
            local_burst_begin <= 1'b1;
            local_addr        <= base_addr;
            wr_cnt            <= '0;
            wr_beat           <= '0;
            pass_seed         <= wr_lfsr;
         end else if (wr_acc) begin
            wr_cnt <= wr_cnt + BEAT_CW'(1);
            if (wr_last) begin
               local_write_req   <= 1'b0;
               local_burst_begin <= 1'b0;
            end else if (wr_beat == LAST_IN_BURST) begin
               wr_beat           <= '0;
               local_burst_begin <= 1'b1;
               local_addr        <= local_addr + BURST_STEP;
            end else begin
               wr_beat           <= wr_beat + SIZE_WIDTH'(1);
               local_burst_begin <= 1'b0;
            end
         end

         if (state_next == ST_READ) begin
            local_read_req    <= rreq_next;
            local_burst_begin <= rreq_next;
            if (state != ST_READ) begin
               local_addr <= base_addr;
               rd_cnt     <= '0;
               ret_beat   <= '0;
               chk_addr   <= base_addr;
               chk_lfsr   <= pass_seed;
            end else if (rd_acc) begin
               local_addr <= local_addr + BURST_STEP;
               rd_cnt     <= rd_cnt + REQ_CW'(1);
            end
         end else begin
            local_read_req <= 1'b0;
            if (state == ST_READ) local_burst_begin <= 1'b0;
         end

         if (rd_ret) begin
            chk_lfsr <= lfsr_adv(chk_lfsr);
            chk_addr <= chk_addr + ADDR_WIDTH'(1);
            ret_beat <= (ret_beat == LAST_IN_BURST) ? '0 : ret_beat + SIZE_WIDTH'(1);
            if (lane_err != '0) begin
               err_lanes <= err_lanes | lane_err;
               if (err_count != '1) err_count <= err_count + 32'd1;
               if (!err_seen) begin
                  first_err_addr <= chk_addr;
                  err_seen       <= 1'b1;
               end
            end
         end

         if ((state == ST_DRAIN) && (state_next != ST_DRAIN)) pass_count <= pass_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_bts_mem_traffic_gen.sv
// Directed bench for bts_mem_traffic_gen: in-order loopback memory, PRBS reference model,
// clean/inject/stall/reset/loop scenarios on a 64-bit, 2x4-beat configuration.
module tb_bts_mem_traffic_gen;

   localparam int          DW      = 64;
   localparam int          BW      = 8;
   localparam int          AW      = 23;
   localparam int          SW      = 3;
   localparam int          BL      = 4;
   localparam int          NB      = 2;
   localparam int          MAX_OUT = 1;
   localparam logic [31:0] SEED    = 32'h1234_5678;
   localparam logic [22:0] BASE    = 23'h100;

   logic          local_clk;
   logic          local_reset;
   logic          start;
   logic          inject_err;
   logic          loop;
   logic [AW-1:0] base_addr;
   logic          local_init_done;
   logic          local_ready;
   logic [AW-1:0] local_addr;
   logic [SW-1:0] local_size;
   logic [BW-1:0] local_be;
   logic          local_burst_begin;
   logic          local_write_req;
   logic [DW-1:0] local_wdata;
   logic          local_read_req;
   logic [DW-1:0] local_rdata;
   logic          local_rdata_valid;
   logic          busy;
   logic          test_complete;
   logic [BW-1:0] err_lanes;
   logic [31:0]   err_count;
   logic [AW-1:0] first_err_addr;
   logic [15:0]   pass_count;

   bts_mem_traffic_gen #(
      .DATA_WIDTH(DW), .BE_WIDTH(BW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW),
      .BURST_LEN(BL), .NUM_BURSTS(NB), .MAX_OUTSTANDING(MAX_OUT), .SEED(SEED)
   ) dut (
      .local_clk(local_clk), .local_reset(local_reset), .start(start),
      .inject_err(inject_err), .loop(loop), .base_addr(base_addr),
      .local_init_done(local_init_done), .local_ready(local_ready),
      .local_addr(local_addr), .local_size(local_size), .local_be(local_be),
      .local_burst_begin(local_burst_begin), .local_write_req(local_write_req),
      .local_wdata(local_wdata), .local_read_req(local_read_req),
      .local_rdata(local_rdata), .local_rdata_valid(local_rdata_valid),
      .busy(busy), .test_complete(test_complete), .err_lanes(err_lanes),
      .err_count(err_count), .first_err_addr(first_err_addr), .pass_count(pass_count)
   );

   initial local_clk = 1'b0;
   always #5 local_clk = ~local_clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Shared between the memory model and the main sequence.
   int          ready_mode = 0;
   logic [31:0] lf;
   int          wr_k, inj_k, pass_beat;
   int          n_wr, n_rd, wd_bad, bb_bad, stall_viol, stall_cnt, out_viol, obs_out;
   logic [22:0] wr_bursts[$];
   logic [22:0] rd_bursts[$];
   logic [22:0] resp_a[$];
   logic        resp_l[$];
   logic [63:0] mem[logic [22:0]];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] prbs_next(input logic [31:0] s);
      logic fb;
      fb = ^(s & 32'h4800_0000);
      return (s << 1) | {31'b0, fb};
   endfunction

   function automatic logic [63:0] beat_of(input logic [31:0] s);
      return {s[30:0], s[31], s};
   endfunction

   initial begin : mem_model
      logic        prev_stall, drove_last, h_bb;
      logic [63:0] h_wd, e;
      logic [22:0] h_a, cur_base;
      prev_stall = 1'b0;
      drove_last = 1'b0;
      h_bb       = 1'b0;
      h_wd       = '0;
      h_a        = '0;
      cur_base   = '0;
      forever begin
         @(negedge local_clk);
         #1;
         if (local_reset) begin
            resp_a.delete();
            resp_l.delete();
            obs_out           = 0;
            prev_stall        = 1'b0;
            drove_last        = 1'b0;
            local_rdata_valid = 1'b0;
         end else begin
            if (drove_last) obs_out--;
            drove_last = 1'b0;
            case (ready_mode)
               0:       local_ready = 1'b1;
               1:       local_ready = ~local_ready;
               default: local_ready = 1'b0;
            endcase
            if (prev_stall && local_write_req &&
                (local_wdata !== h_wd || local_addr !== h_a || local_burst_begin !== h_bb))
               stall_viol++;
            prev_stall = local_write_req && !local_ready;
            h_wd = local_wdata;
            h_a  = local_addr;
            h_bb = local_burst_begin;
            if (prev_stall) stall_cnt++;
            if (local_read_req && obs_out >= MAX_OUT) out_viol++;
            if (local_write_req && local_ready) begin
               e = beat_of(lf);
               if (wr_k == inj_k) e[0] = ~e[0];
               if (local_wdata !== e) wd_bad++;
               if (local_burst_begin !== ((pass_beat % BL) == 0)) bb_bad++;
               if (local_burst_begin) begin
                  cur_base = local_addr;
                  wr_bursts.push_back(local_addr);
               end
               mem[cur_base + 23'(pass_beat % BL)] = local_wdata;
               lf = prbs_next(lf);
               wr_k++;
               n_wr++;
               pass_beat = (pass_beat == NB*BL - 1) ? 0 : pass_beat + 1;
            end
            if (resp_a.size() > 0) begin
               local_rdata       = mem.exists(resp_a[0]) ? mem[resp_a[0]] : 64'h0;
               local_rdata_valid = 1'b1;
               drove_last        = resp_l[0];
               void'(resp_a.pop_front());
               void'(resp_l.pop_front());
            end else begin
               local_rdata_valid = 1'b0;
            end
            if (local_read_req && local_ready) begin
               if (!local_burst_begin) bb_bad++;
               rd_bursts.push_back(local_addr);
               for (int b = 0; b < BL; b++) begin
                  resp_a.push_back(local_addr + 23'(b));
                  resp_l.push_back(b == BL - 1);
               end
               obs_out++;
               n_rd++;
            end
         end
      end
   end

   task automatic cyc();
      @(negedge local_clk);
      #2;
   endtask

   task automatic start_test(input int inj);
      n_wr = 0; n_rd = 0; wd_bad = 0; bb_bad = 0;
      stall_viol = 0; stall_cnt = 0; out_viol = 0;
      wr_bursts.delete();
      rd_bursts.delete();
      lf = SEED; wr_k = 0; inj_k = inj; pass_beat = 0;
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!test_complete && n < 2000) begin
         cyc();
         n++;
      end
      check({tag, "_complete"}, 64'(test_complete), 64'd1);
   endtask

   task automatic check_pass(input string tag, input logic [7:0] lanes, input int cnt,
                             input logic [22:0] first, input int passes);
      int wb, rb;
      wb = 0;
      rb = 0;
      foreach (wr_bursts[i]) if (wr_bursts[i] !== BASE + 23'(BL * (i % NB))) wb++;
      foreach (rd_bursts[i]) if (rd_bursts[i] !== BASE + 23'(BL * (i % NB))) rb++;
      check({tag, "_busy"},       64'(busy),           64'd0);
      check({tag, "_err_lanes"},  64'(err_lanes),      64'(lanes));
      check({tag, "_err_count"},  64'(err_count),      64'(cnt));
      check({tag, "_first_err"},  64'(first_err_addr), 64'(first));
      check({tag, "_pass_count"}, 64'(pass_count),     64'(passes));
      check({tag, "_wr_beats"},   64'(n_wr),           64'(NB * BL * passes));
      check({tag, "_rd_reqs"},    64'(n_rd),           64'(NB * passes));
      check({tag, "_wr_addr"},    64'(wb),             64'd0);
      check({tag, "_rd_addr"},    64'(rb),             64'd0);
      check({tag, "_wdata"},      64'(wd_bad),         64'd0);
      check({tag, "_burst_beg"},  64'(bb_bad),         64'd0);
      check({tag, "_outstand"},   64'(out_viol),       64'd0);
   endtask

   initial begin : main
      local_reset = 1'b1; start = 1'b0; inject_err = 1'b0; loop = 1'b0;
      base_addr = BASE; local_init_done = 1'b0; local_ready = 1'b1;
      local_rdata = '0; local_rdata_valid = 1'b0;
      lf = SEED; wr_k = 0; inj_k = -1; pass_beat = 0;
      repeat (3) cyc();
      local_reset = 1'b0;
      cyc();
      check("rst_write_req", 64'(local_write_req),   64'd0);
      check("rst_read_req",  64'(local_read_req),    64'd0);
      check("rst_burst_beg", 64'(local_burst_begin), 64'd0);
      check("rst_addr",      64'(local_addr),        64'd0);
      check("rst_size",      64'(local_size),        64'd4);
      check("rst_be",        64'(local_be),          64'hff);
      check("rst_wdata",     local_wdata,            64'd0);
      check("rst_busy",      64'(busy),              64'd0);
      check("rst_complete",  64'(test_complete),     64'd0);
      check("rst_err",       64'(err_count),         64'd0);
      check("rst_pass",      64'(pass_count),        64'd0);

      // Clean pass, ready always high.
      local_init_done = 1'b1;
      start_test(-1);
      wait_done("clean");
      check_pass("clean", 8'h00, 0, 23'h0, 1);

      // Corrupt beat 0: inject arrives on the cycle calibration completes.
      local_init_done = 1'b0;
      start_test(0);
      cyc();
      check("winit_busy",  64'(busy),            64'd1);
      check("winit_write", 64'(local_write_req), 64'd0);
      local_init_done = 1'b1;
      inject_err      = 1'b1;
      cyc();
      inject_err = 1'b0;
      wait_done("inject");
      check_pass("inject", 8'h01, 1, BASE, 1);

      // Ready toggling every cycle.
      ready_mode = 1;
      start_test(-1);
      wait_done("toggle");
      check_pass("toggle", 8'h00, 0, 23'h0, 1);
      check("toggle_stalls", 64'(stall_cnt > 0), 64'd1);
      check("toggle_stable", 64'(stall_viol),    64'd0);

      // Reset while a write beat is stalled.
      ready_mode = 2;
      start_test(-1);
      repeat (3) cyc();
      check("midwr_active", 64'(local_write_req), 64'd1);
      local_reset = 1'b1;
      cyc();
      check("midwr_write_req", 64'(local_write_req),   64'd0);
      check("midwr_read_req",  64'(local_read_req),    64'd0);
      check("midwr_burst_beg", 64'(local_burst_begin), 64'd0);
      check("midwr_busy",      64'(busy),              64'd0);
      local_reset = 1'b0;
      ready_mode  = 0;
      cyc();
      start_test(-1);
      wait_done("rerun");
      check_pass("rerun", 8'h00, 0, 23'h0, 1);

      // Continuous mode.
      loop = 1'b1;
      start_test(-1);
`ifdef BTS_TGEN_LOOP_EN
      begin
         int n;
         n = 0;
         while (pass_count != 16'd3 && n < 2000) begin
            cyc();
            n++;
         end
         check("loop_reach3", 64'(pass_count), 64'd3);
      end
      loop = 1'b0;
      wait_done("loop");
      check_pass("loop", 8'h00, 0, 23'h0, 4);
`else
      wait_done("loop");
      loop = 1'b0;
      check_pass("loop", 8'h00, 0, 23'h0, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
